libv_demux_stream: RTL and testbench

//   Stream demultiplexer: routes one valid/accept input stream to one of N

---
 rtl/libv_demux_stream_pkg.sv | 10 +
 rtl/libv_demux_stream_if.sv | 25 ++
 rtl/libv_demux_stream_lane.sv | 76 +++++++
 rtl/libv_demux_stream.sv | 45 ++++
 tb/tb_libv_demux_stream.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/libv_demux_stream_pkg.sv
// Shared helpers for the stream demultiplexer slice.
// Imported by the top level for select validation.
package libv_demux_stream_pkg;

  // Operand is zero-extended by the caller, so this covers any lane count up to 64.
  function automatic logic is_onehot(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/libv_demux_stream_if.sv
// Handshake bundle for libv_demux_stream: one input stream and N output lanes.
// The master modport is the stream source / lane sinks; the slave modport is the demux.
interface libv_demux_stream_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic                  in_vld;
  logic [N-1:0]          in_sel;
  logic [W-1:0]          in_w;
  logic                  in_accept;
  logic [N-1:0]          out_vld;
  logic [N-1:0][W-1:0]   out_w;
  logic [N-1:0]          out_accept;
  logic                  err;

  modport master (
    output in_vld, in_sel, in_w, out_accept,
    input  in_accept, out_vld, out_w, err
  );

  modport slave (
    input  in_vld, in_sel, in_w, out_accept,
    output in_accept, out_vld, out_w, err
  );
endinterface

// File: rtl/libv_demux_stream_lane.sv
// One output lane of the demux. Define LIBV_DEMUX_STREAM_SKID_EN for a
// 2-entry skid buffer with a registered ready; otherwise a single register stage.
module libv_demux_stream_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_w,
  output logic         rdy,
  output logic         vld,
  output logic [W-1:0] w,
  input  logic         accept
);

`ifdef LIBV_DEMUX_STREAM_SKID_EN
  logic         main_full;
  logic [W-1:0] main_d;
  logic         skid_full;
  logic [W-1:0] skid_d;
  logic         pop;

  assign pop = main_full & accept;
  assign rdy = ~skid_full;
  assign vld = main_full;
  assign w   = main_d;

  // Skid only fills when main is occupied and not draining, so main is never empty behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_full <= 1'b0;
      skid_full <= 1'b0;
    end else if (pop) begin
      if (skid_full) begin
        main_d <= skid_d;
        if (push) begin
          skid_d <= push_w;
        end else begin
          skid_full <= 1'b0;
        end
      end else if (push) begin
        main_d <= push_w;
      end else begin
        main_full <= 1'b0;
      end
    end else if (push) begin
      if (!main_full) begin
        main_full <= 1'b1;
        main_d    <= push_w;
      end else begin
        skid_full <= 1'b1;
        skid_d    <= push_w;
      end
    end
  end
`else
  logic         full;
  logic [W-1:0] data;

  assign rdy = ~full | accept;
  assign vld = full;
  assign w   = data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      data <= push_w;
    end else if (accept) begin
      full <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/libv_demux_stream.sv
// Stream demultiplexer: routes each beat to the lane named by its one-hot select.
// Lane buffering depth is selected by LIBV_DEMUX_STREAM_SKID_EN (see lane sub-module).
module libv_demux_stream
  import libv_demux_stream_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  libv_demux_stream_if.slave    bus
);

  logic         sel_ok;
  logic [N-1:0] lane_rdy;
  logic [N-1:0] push;

  assign sel_ok = is_onehot(64'(bus.in_sel));

  // Bad selects are always swallowed so a malformed beat can never wedge the source.
  assign bus.in_accept = sel_ok ? |(bus.in_sel & lane_rdy) : 1'b1;
  assign push          = {N{bus.in_vld & sel_ok}} & bus.in_sel & lane_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.err <= 1'b0;
    end else begin
      bus.err <= bus.in_vld & ~sel_ok;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    libv_demux_stream_lane #(.W(W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push[i]),
      .push_w (bus.in_w),
      .rdy    (lane_rdy[i]),
      .vld    (bus.out_vld[i]),
      .w      (bus.out_w[i]),
      .accept (bus.out_accept[i])
    );
  end

endmodule

// File: tb/tb_libv_demux_stream.sv
// Directed self-checking bench for libv_demux_stream (N=4, W=32); expectations
// follow LIBV_DEMUX_STREAM_SKID_EN when it is defined for the build.
module tb_libv_demux_stream;

  localparam int N = 4;
  localparam int W = 32;

`ifdef LIBV_DEMUX_STREAM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;

  libv_demux_stream_if #(.N(N), .W(W)) bus ();

  libv_demux_stream #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [N-1:0] sel, input logic [W-1:0] w);
    bus.in_vld = vld;
    bus.in_sel = sel;
    bus.in_w   = w;
    #1;
  endtask

  initial begin
    logic [W-1:0] drain_exp [3];
    logic [W-1:0] send_q    [2];
    int popped;
    int sent;

    drain_exp = '{32'h11, 32'h12, 32'h13};
    send_q    = '{32'h12, 32'h13};

    rst_n = 1'b0;
    bus.out_accept = '0;
    applyStimulus(1'b0, 4'b0000, '0);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    applyStimulus(1'b0, 4'b0001, '0);
    checkOutput("reset_out_vld", 64'(bus.out_vld), 64'h0);
    checkOutput("reset_err", 64'(bus.err), 64'h0);
    checkOutput("reset_in_accept", 64'(bus.in_accept), 64'h1);

    // Single beat to lane 2
    bus.out_accept = 4'b1111;
    applyStimulus(1'b1, 4'b0100, 32'hCAFE_0001);
    checkOutput("l2_in_accept", 64'(bus.in_accept), 64'h1);
    tick();
    applyStimulus(1'b0, 4'b0000, '0);
    checkOutput("l2_out_vld", 64'(bus.out_vld), 64'h4);
    checkOutput("l2_out_w", 64'(bus.out_w[2]), 64'hCAFE_0001);
    tick();
    checkOutput("l2_drained", 64'(bus.out_vld), 64'h0);

    // Back-to-back beats to lane 0 with sink always accepting
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b0001, 32'hC0 + 32'(i));
      checkOutput("b2b_in_accept", 64'(bus.in_accept), 64'h1);
      tick();
      applyStimulus(1'b0, 4'b0000, '0);
      checkOutput("b2b_out_vld", 64'(bus.out_vld), 64'h1);
      checkOutput("b2b_out_w", 64'(bus.out_w[0]), 64'hC0 + 64'(i));
    end
    tick();

    // Stall lane 1 and push beats until backpressure
    bus.out_accept = 4'b1101;
    applyStimulus(1'b1, 4'b0010, 32'h11);
    checkOutput("stall_b1_accept", 64'(bus.in_accept), 64'h1);
    tick();
    sent = 0;
    applyStimulus(1'b1, 4'b0010, 32'h12);
    checkOutput("stall_b2_accept", 64'(bus.in_accept), SKID ? 64'h1 : 64'h0);
    if (SKID) begin
      tick();
      sent = 1;
      applyStimulus(1'b1, 4'b0010, 32'h13);
      checkOutput("stall_b3_accept", 64'(bus.in_accept), 64'h0);
    end
    checkOutput("stall_hold_w", 64'(bus.out_w[1]), 64'h11);

    // Lane 3 bypasses the stalled lane 1
    applyStimulus(1'b1, 4'b1000, 32'hAA);
    checkOutput("hol_in_accept", 64'(bus.in_accept), 64'h1);
    tick();
    applyStimulus(1'b0, 4'b0000, '0);
    checkOutput("hol_out_vld", 64'(bus.out_vld), 64'hA);
    checkOutput("hol_out_w3", 64'(bus.out_w[3]), 64'hAA);
    checkOutput("hol_hold_w1", 64'(bus.out_w[1]), 64'h11);

    // Release lane 1, feed the remaining beats, and check drain order
    bus.out_accept = 4'b1111;
    popped = 0;
    for (int cyc = 0; cyc < 20 && (popped < 3 || sent < 2); cyc++) begin
      if (sent < 2) applyStimulus(1'b1, 4'b0010, send_q[sent]);
      else          applyStimulus(1'b0, 4'b0000, '0);
      if (bus.out_vld[1]) begin
        if (popped < 3) checkOutput("drain_order", 64'(bus.out_w[1]), 64'(drain_exp[popped]));
        popped++;
      end
      if (bus.in_vld && bus.in_accept) sent++;
      tick();
    end
    applyStimulus(1'b0, 4'b0000, '0);
    checkOutput("drain_count", 64'(popped), 64'd3);
    checkOutput("drain_sent", 64'(sent), 64'd2);
    checkOutput("drain_empty", 64'(bus.out_vld), 64'h0);

    // Bad selects are swallowed and flagged one cycle later
    applyStimulus(1'b1, 4'b0000, 32'hDEAD);
    checkOutput("bad0_in_accept", 64'(bus.in_accept), 64'h1);
    tick();
    applyStimulus(1'b1, 4'b0110, 32'hBEEF);
    checkOutput("bad1_in_accept", 64'(bus.in_accept), 64'h1);
    checkOutput("bad0_err", 64'(bus.err), 64'h1);
    checkOutput("bad0_out_vld", 64'(bus.out_vld), 64'h0);
    tick();
    applyStimulus(1'b0, 4'b0000, '0);
    checkOutput("bad1_err", 64'(bus.err), 64'h1);
    checkOutput("bad1_out_vld", 64'(bus.out_vld), 64'h0);
    tick();
    checkOutput("bad_err_clear", 64'(bus.err), 64'h0);

    // Reset discards buffered data in stalled lanes
    bus.out_accept = 4'b0000;
    applyStimulus(1'b1, 4'b0001, 32'hA0);
    tick();
    applyStimulus(1'b1, 4'b0100, 32'hA2);
    tick();
    applyStimulus(1'b0, 4'b0000, '0);
    checkOutput("prerst_out_vld", 64'(bus.out_vld), 64'h5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rst_out_vld", 64'(bus.out_vld), 64'h0);
    checkOutput("rst_err", 64'(bus.err), 64'h0);
    bus.out_accept = 4'b1111;
    tick();
    checkOutput("rst_no_stale", 64'(bus.out_vld), 64'h0);
    applyStimulus(1'b1, 4'b0001, 32'hB0);
    tick();
    applyStimulus(1'b0, 4'b0000, '0);
    checkOutput("rst_fresh_vld", 64'(bus.out_vld), 64'h1);
    checkOutput("rst_fresh_w", 64'(bus.out_w[0]), 64'hB0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
